// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for parity_frame_unit.
//   state_t   : frame FSM state (ST_DATA accepting data words, ST_LRC block-check beat)
//   MODE_GEN  : generate parity / insert LRC
//   MODE_CHK  : check received parity / LRC
//   ERR_CNT_W : width of the optional saturating error counter
package parity_pkg;
  typedef enum logic {ST_DATA, ST_LRC} state_t;

  localparam logic MODE_GEN  = 1'b0;
  localparam logic MODE_CHK  = 1'b1;
  localparam int   ERR_CNT_W = 16;
endpackage

// File: rtl/parity_frame_unit_if.sv
// parity_frame_unit_if: input and output valid/ready streams of parity_frame_unit.
//   in_*  : word source -> unit (in_par only meaningful in check mode)
//   out_* : unit -> link; out_data = {parity, word}, out_lrc marks the block-check beat,
//           out_err flags a check-mode mismatch on that beat
// Modports: master = stream source/sink side, slave = the unit.
interface parity_frame_unit_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             out_lrc;
  logic             out_err;

  modport master (output in_valid, in_data, in_par, out_ready,
                  input  in_ready, out_valid, out_data, out_lrc, out_err);
  modport slave  (input  in_valid, in_data, in_par, out_ready,
                  output in_ready, out_valid, out_data, out_lrc, out_err);
endinterface

// File: rtl/parity_calc.sv
// parity_calc: combinational word parity p(w) = ^w ^ ODD.
//   w : word in (WIDTH bits)
//   p : parity bit out (even when ODD = 0, odd when ODD = 1)
module parity_calc #(
  parameter int WIDTH = 4,
  parameter int ODD   = 0
) (
  input  logic [WIDTH-1:0] w,
  output logic             p
);
  assign p = (^w) ^ (ODD != 0);
endmodule

// File: rtl/parity_frame_unit.sv
// parity_frame_unit: pipelined parity generator/checker with per-frame LRC word.
// Generate mode appends p(word) to each word and inserts {p(acc), acc} after every
// FRAME_LEN words; check mode verifies received parity bits and the received LRC.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   mode     : 0 generate / 1 check, latched on the first beat of each frame
//   bus      : parity_frame_unit_if.slave (input and output streams)
//   err_cnt, err_clr : saturating error counter and its clear, present only when
//                      PARITY_ERR_CNT_EN is defined
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
`ifdef PARITY_ERR_CNT_EN
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  parity_frame_unit_if.slave   bus
);
  localparam int             IW   = $clog2(FRAME_LEN + 1);
  localparam logic [IW-1:0]  LAST = IW'(FRAME_LEN - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic             fmode;

  logic             ov, olrc, oerr;
  logic [WIDTH:0]   od;

  logic             p_in, p_acc;
  logic             out_free, fire_in, beat_mode;

  parity_calc #(.WIDTH(WIDTH), .ODD(ODD)) u_par_in  (.w(bus.in_data), .p(p_in));
  parity_calc #(.WIDTH(WIDTH), .ODD(ODD)) u_par_acc (.w(acc),         .p(p_acc));

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free     = ~ov | bus.out_ready;
  assign bus.in_ready = ((state == ST_DATA) || (fmode == MODE_CHK)) && out_free;
  assign fire_in      = bus.in_valid & bus.in_ready;
  // First beat of a frame uses the live mode; later beats use the latched one.
  assign beat_mode    = (idx == '0) ? mode : fmode;

  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_lrc   = olrc;
  assign bus.out_err   = oerr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DATA;
      idx   <= '0;
      acc   <= '0;
      fmode <= MODE_GEN;
      ov    <= 1'b0;
      od    <= '0;
      olrc  <= 1'b0;
      oerr  <= 1'b0;
    end else begin
      // Drain first; a load below in the same cycle overrides it.
      if (ov && bus.out_ready) ov <= 1'b0;
      unique case (state)
        ST_DATA: if (fire_in) begin
          if (idx == '0) fmode <= mode;
          acc  <= acc ^ bus.in_data;
          idx  <= idx + IW'(1);
          ov   <= 1'b1;
          olrc <= 1'b0;
          if (beat_mode == MODE_CHK) begin
            od   <= {bus.in_par, bus.in_data};
            oerr <= bus.in_par != p_in;
          end else begin
            od   <= {p_in, bus.in_data};
            oerr <= 1'b0;
          end
          if (idx == LAST) state <= ST_LRC;
        end
        ST_LRC: begin
          if (fmode == MODE_GEN) begin
            // Inserted beat: no input consumed, costs one input bubble.
            if (out_free) begin
              ov    <= 1'b1;
              od    <= {p_acc, acc};
              olrc  <= 1'b1;
              oerr  <= 1'b0;
              acc   <= '0;
              idx   <= '0;
              state <= ST_DATA;
            end
          end else if (fire_in) begin
            ov    <= 1'b1;
            od    <= {bus.in_par, bus.in_data};
            olrc  <= 1'b1;
            oerr  <= (bus.in_data != acc) | (bus.in_par != p_in);
            acc   <= '0;
            idx   <= '0;
            state <= ST_DATA;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Counts transferred error beats; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr)
      err_cnt <= '0;
    else if (ov && bus.out_ready && oerr && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + ERR_CNT_W'(1);
  end
`endif
endmodule
